complex_mac_seq: RTL
====================

Name: complex_mac_seq

Overview:
- Sequential, parametrised successor to the combinational complex multiplier.
- Uses one shared signed WIDTH/2 x WIDTH/2 multiplier over four cycles.
- Supports plain multiply, conjugate multiply and complex multiply-accumulate, with a start/busy/done handshake.
- Operand and result packing are unchanged from the existing complex unit, so it is a drop-in for datapaths that can tolerate multi-cycle latency.

Parameters:
- WIDTH, 32: packed operand width. Real part is bits [WIDTH/2-1:0], imag part is bits [WIDTH-1:WIDTH/2], both signed two's complement. WIDTH must be even and >= 4.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE or DONE
- mode  in  2  00 a*b; 01 a*conj(b); 10 acc += a*b; 11 acc = a*b (clear then load)
- a  in  WIDTH  packed complex operand
- b  in  WIDTH  packed complex operand
- busy  out  1  high while computing
- done  out  1  one-cycle pulse: result updated
- result  out  2*WIDTH  real in [WIDTH-1:0], imag in [2*WIDTH-1:WIDTH], each signed WIDTH bits

Behaviour:
- Reset (async assert, sync release): state=IDLE, busy=0, done=0, result=0, internal accumulator=0, latched operands/mode=0.
- Operand unpack: each part is sign-extended from WIDTH/2 bits. Every partial product is an exact signed WIDTH-bit value.
- FSM: IDLE, M0, M1, M2, M3, DONE.
  - IDLE: on start=1, latch a, b and mode; go to M0. Otherwise stay.
  - M0: product ar*br into real partial.
  - M1: ai*bi. Subtract from real partial for modes 00/10/11; add for mode 01.
  - M2: ar*bi into imag partial. Negated for mode 01.
  - M3: ai*br added to imag partial. Update the result register and the accumulator at the end of this cycle; go to DONE.
  - DONE: done=1 for exactly this cycle. On start=1, latch new operands and go to M0 (back-to-back issue). Otherwise go to IDLE.
- Timing: busy=1 in M0..M3 only. With start sampled at edge N, done is high during the cycle after edge N+4. Throughput is one op per 5 cycles.
- start while busy is ignored; there is no queueing. a, b and mode may change freely after the accepting edge.
- Mode 00/01: result = product; accumulator := product.
- Mode 10: result = accumulator + product; accumulator := same.
- Mode 11: identical to 00. It exists to make the start of a MAC sequence explicit.
- Arithmetic: internal partial sums are WIDTH+2 bits. Final real/imag values are reduced to WIDTH bits by two's-complement wrap, i.e. truncation (see Optional Feature).
- result holds its value between operations. It changes only at the M3 update.
- Reset mid-operation aborts immediately: no done pulse, result and accumulator cleared.

Optional Feature:
- Macro: CMAC_SATURATE_EN.
- Defined: each component is clamped at the M3 update to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. The accumulator stores the clamped value.
- Undefined: each component wraps modulo 2^WIDTH.
- Handshake and latency are identical in both builds.

Test Plan:
- WIDTH=32, mode=00, a=0x0004_0003 (3+4j), b=0xFFFE_0001 (1-2j) -> done 5 cycles after start edge; result real=0x0000000B, imag=0xFFFFFFFE (11-2j); busy high for exactly 4 cycles.
- Same operands, mode=01 -> real=0xFFFFFFFB, imag=0x0000000A (-5+10j).
- mode=11 with a=b=0x0000_8000 (-32768), then mode=10 with the same operands -> first result real=0x40000000; second is 0x80000000 without CMAC_SATURATE_EN, 0x7FFFFFFF with it; imag=0 both times.
- start held high continuously -> ops accepted at the IDLE edge and at every DONE cycle; done pulses every 5 cycles; start pulses during M0..M3 produce no extra done.
- rst_n asserted in M2 -> busy, done and result go to 0 asynchronously; after release, a new start completes normally and mode=10 accumulates from 0.
- Idle hold: after done, change a and b without start for 20 cycles -> result unchanged, done stays 0.

Source files
------------

// File: rtl/complex_mac_seq.sv
// Purpose: sequential complex multiply / conjugate multiply / multiply-accumulate built around one shared signed multiplier.
// Latency: start sampled at edge N -> done pulses for one cycle after edge N+4; one op per 5 cycles, back-to-back from DONE.
// Backpressure: none; start is ignored while busy, no queueing. a/b/mode are latched on the accepting edge.
//
// Ports:
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   start, mode   request and op select (00 a*b, 01 a*conj(b), 10 acc+=a*b, 11 acc=a*b)
//   a, b          packed complex operands: real [WIDTH/2-1:0], imag [WIDTH-1:WIDTH/2]
//   busy, done    busy in M0..M3; done is a one-cycle pulse when result updates
//   result        real [WIDTH-1:0], imag [2*WIDTH-1:WIDTH]
// Build option: define CMAC_SATURATE_EN to clamp each result component instead of wrapping.

module complex_mac_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int H  = WIDTH / 2;
  localparam int PW = WIDTH + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_M0,
    S_M1,
    S_M2,
    S_M3,
    S_DONE
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [1:0]         mode_q;
  logic signed [PW-1:0]    re_p;
  logic signed [PW-1:0]    im_p;
  logic signed [WIDTH-1:0] acc_re;
  logic signed [WIDTH-1:0] acc_im;

  // Operand parts, sign-extended to WIDTH so the product is exact.
  logic signed [WIDTH-1:0] ar, ai, br, bi;
  assign ar = {{(WIDTH-H){a_q[H-1]}},     a_q[H-1:0]};
  assign ai = {{(WIDTH-H){a_q[WIDTH-1]}}, a_q[WIDTH-1:H]};
  assign br = {{(WIDTH-H){b_q[H-1]}},     b_q[H-1:0]};
  assign bi = {{(WIDTH-H){b_q[WIDTH-1]}}, b_q[WIDTH-1:H]};

  // Shared multiplier: operand pair selected by the current step.
  logic signed [WIDTH-1:0] mul_x, mul_y, prod;
  always_comb begin
    mul_x = ar;
    mul_y = br;
    case (state)
      S_M1:    begin mul_x = ai; mul_y = bi; end
      S_M2:    begin mul_x = ar; mul_y = bi; end
      S_M3:    begin mul_x = ai; mul_y = br; end
      default: begin mul_x = ar; mul_y = br; end
    endcase
  end
  assign prod = mul_x * mul_y;

  logic signed [PW-1:0] prod_x;
  assign prod_x = {{2{prod[WIDTH-1]}}, prod};

  // Final sums formed during M3; the accumulator joins in only for mode 10.
  logic signed [PW-1:0] acc_add_re, acc_add_im, sum_re, sum_im;
  always_comb begin
    acc_add_re = '0;
    acc_add_im = '0;
    if (mode_q == 2'b10) begin
      acc_add_re = {{2{acc_re[WIDTH-1]}}, acc_re};
      acc_add_im = {{2{acc_im[WIDTH-1]}}, acc_im};
    end
  end
  assign sum_re = re_p + acc_add_re;
  assign sum_im = im_p + prod_x + acc_add_im;

  logic [WIDTH-1:0] fin_re, fin_im;

`ifdef CMAC_SATURATE_EN
  // In range when the bits above the WIDTH-bit sign position all match it.
  function automatic logic [WIDTH-1:0] clamp(input logic [PW-1:0] v);
    if (v[PW-1:WIDTH-1] == {(PW-WIDTH+1){1'b0}} ||
        v[PW-1:WIDTH-1] == {(PW-WIDTH+1){1'b1}})
      return v[WIDTH-1:0];
    else if (v[PW-1])
      return {1'b1, {(WIDTH-1){1'b0}}};
    else
      return {1'b0, {(WIDTH-1){1'b1}}};
  endfunction
  assign fin_re = clamp(sum_re);
  assign fin_im = clamp(sum_im);
`else
  // Two's-complement wrap: the guard bits are simply dropped.
  assign fin_re = sum_re[WIDTH-1:0];
  assign fin_im = sum_im[WIDTH-1:0];
  logic unused_sum_hi;
  assign unused_sum_hi = ^{sum_re[PW-1:WIDTH], sum_im[PW-1:WIDTH]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= '0;
      re_p   <= '0;
      im_p   <= '0;
      acc_re <= '0;
      acc_im <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            mode_q <= mode;
            busy   <= 1'b1;
            state  <= S_M0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_M0: begin
          re_p  <= prod_x;
          state <= S_M1;
        end
        S_M1: begin
          // Conjugate flips the sign of the ai*bi contribution.
          re_p  <= (mode_q == 2'b01) ? re_p + prod_x : re_p - prod_x;
          state <= S_M2;
        end
        S_M2: begin
          im_p  <= (mode_q == 2'b01) ? -prod_x : prod_x;
          state <= S_M3;
        end
        S_M3: begin
          result <= {fin_im, fin_re};
          acc_re <= fin_re;
          acc_im <= fin_im;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= S_DONE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
